// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: FSM state encoding,
// opcode/funct values and datapath mux/ALU encodings.
// No ports; imported by mips_multicycle_ctrl and alu_decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // FSM-to-decoder ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B-operand mux
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Store is the only memory opcode that takes the write path after MEMADR.
  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps {aluop, funct} to the 3-bit ALU control and flags unknown funct codes.
// Latency: purely combinational. Backpressure: none.
// Ports: i_aluop (00 add, 01 sub, 10 funct), i_funct, o_alu_ctrl, o_funct_illegal.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_funct_illegal
);

  always_comb begin
    o_alu_ctrl      = ALU_ADD;
    o_funct_illegal = 1'b0;
    case (i_aluop)
      ALUOP_ADD: o_alu_ctrl = ALU_ADD;
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_ctrl = ALU_ADD;
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: begin
            // Unknown funct: drive a neutral code, the FSM aborts the instruction.
            o_alu_ctrl      = ALU_AND;
            o_funct_illegal = 1'b1;
          end
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/mem/writeback.
// Latency: Moore outputs from the registered state; lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles.
// Backpressure: mem_req held until mem_ack; each ack-less cycle stalls the FSM one cycle.
// Ports: i_clk, i_rst (sync, active high), i_opcode/i_funct from IR, i_zero from ALU,
//   i_mem_ack from memory port; o_* are all datapath enables, mux selects and status.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ack,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_en,
  output logic [1:0] o_pc_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_ctrl,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_illegal_op,
  output logic       o_busy
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic [2:0] w_dec_alu_ctrl;
  logic       w_funct_illegal;
  logic       w_alu_en;
  logic       w_pc_write;
  logic       w_branch;

  // aluop is derived directly from the state (not from the FSM process) so the
  // decoder's illegal flag can feed next-state logic without a combinational loop.
  assign w_aluop = (r_state == S_EXEC)   ? ALUOP_FUNCT :
                   (r_state == S_BRANCH) ? ALUOP_SUB   : ALUOP_ADD;

  alu_decoder u_alu_decoder (
    .i_aluop         (w_aluop),
    .i_funct         (i_funct),
    .o_alu_ctrl      (w_dec_alu_ctrl),
    .o_funct_illegal (w_funct_illegal)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_alu_en     = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_src     = PCSRC_ALU;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_REG;
    o_reg_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_illegal_op = 1'b0;

    case (r_state)
      S_IDLE: w_next = S_FETCH;

      S_FETCH: begin
        o_mem_req   = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        w_alu_en    = 1'b1;
        // IR load and PC+4 only in the ack cycle: one increment per instruction.
        o_ir_write  = i_mem_ack;
        w_pc_write  = i_mem_ack;
        if (i_mem_ack) w_next = S_DECODE;
      end

      S_DECODE: begin
        o_alu_src_b = SRCB_IMM_SH2;
        w_alu_en    = 1'b1;
        case (i_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            o_illegal_op = 1'b1;
            w_next       = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        w_alu_en    = 1'b1;
        w_next      = is_store(i_opcode) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
        if (i_mem_ack) w_next = S_MEMWB;
      end

      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end

      S_MEMWR: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        o_iord    = 1'b1;
        if (i_mem_ack) w_next = S_FETCH;
      end

      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_REG;
        w_alu_en    = 1'b1;
        if (w_funct_illegal) begin
          o_illegal_op = 1'b1;
          w_next       = S_FETCH;
        end else begin
          w_next = S_ALUWB;
        end
      end

      S_ALUWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
        w_next      = S_FETCH;
      end

      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_REG;
        w_alu_en    = 1'b1;
        w_branch    = 1'b1;
        o_pc_src    = PCSRC_ALUOUT;
        w_next      = S_FETCH;
      end

      S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        w_alu_en    = 1'b1;
        w_next      = S_ADDIWB;
      end

      S_ADDIWB: begin
        o_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      S_JUMP: begin
        w_pc_write = 1'b1;
        o_pc_src   = PCSRC_JUMP;
        w_next     = S_FETCH;
      end

      default: w_next = S_IDLE;
    endcase
  end

  assign o_pc_en    = w_pc_write | (w_branch & i_zero);
  // ALU control reads 000 in states that do not use the ALU.
  assign o_alu_ctrl = w_alu_en ? w_dec_alu_ctrl : ALU_AND;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle output vectors compared
// against hand-computed expectations for each instruction class.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;

  logic       mem_req, mem_we, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op, busy;

  mips_multicycle_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_opcode     (opcode),
    .i_funct      (funct),
    .i_zero       (zero),
    .i_mem_ack    (mem_ack),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_iord       (iord),
    .o_ir_write   (ir_write),
    .o_pc_en      (pc_en),
    .o_pc_src     (pc_src),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_alu_ctrl   (alu_ctrl),
    .o_reg_write  (reg_write),
    .o_reg_dst    (reg_dst),
    .o_mem_to_reg (mem_to_reg),
    .o_illegal_op (illegal_op),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Bit order: [17]mem_req [16]mem_we [15]iord [14]ir_write [13]pc_en [12:11]pc_src
  // [10]alu_src_a [9:8]alu_src_b [7:5]alu_ctrl [4]reg_write [3]reg_dst [2]mem_to_reg
  // [1]illegal_op [0]busy
  wire [17:0] obs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
                     alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal_op, busy};

  localparam logic [17:0] E_IDLE       = 18'b0_0_0_0_0_00_0_00_000_0_0_0_0_0;
  localparam logic [17:0] E_FETCH      = 18'b1_0_0_0_0_00_0_01_010_0_0_0_0_1;
  localparam logic [17:0] E_FETCH_ACK  = 18'b1_0_0_1_1_00_0_01_010_0_0_0_0_1;
  localparam logic [17:0] E_DECODE     = 18'b0_0_0_0_0_00_0_11_010_0_0_0_0_1;
  localparam logic [17:0] E_DECODE_ILL = 18'b0_0_0_0_0_00_0_11_010_0_0_0_1_1;
  localparam logic [17:0] E_MEMADR     = 18'b0_0_0_0_0_00_1_10_010_0_0_0_0_1;
  localparam logic [17:0] E_MEMRD      = 18'b1_0_1_0_0_00_0_00_000_0_0_0_0_1;
  localparam logic [17:0] E_MEMWB      = 18'b0_0_0_0_0_00_0_00_000_1_0_1_0_1;
  localparam logic [17:0] E_MEMWR      = 18'b1_1_1_0_0_00_0_00_000_0_0_0_0_1;
  localparam logic [17:0] E_EXEC_ADD   = 18'b0_0_0_0_0_00_1_00_010_0_0_0_0_1;
  localparam logic [17:0] E_EXEC_ILL   = 18'b0_0_0_0_0_00_1_00_000_0_0_0_1_1;
  localparam logic [17:0] E_ALUWB      = 18'b0_0_0_0_0_00_0_00_000_1_1_0_0_1;
  localparam logic [17:0] E_BR_T       = 18'b0_0_0_0_1_01_1_00_110_0_0_0_0_1;
  localparam logic [17:0] E_BR_NT      = 18'b0_0_0_0_0_01_1_00_110_0_0_0_0_1;
  localparam logic [17:0] E_ADDIEX     = 18'b0_0_0_0_0_00_1_10_010_0_0_0_0_1;
  localparam logic [17:0] E_ADDIWB     = 18'b0_0_0_0_0_00_0_00_000_1_0_0_0_1;
  localparam logic [17:0] E_JUMP       = 18'b0_0_0_0_1_10_0_00_000_0_0_0_0_1;

  int checks = 0;
  int errors = 0;

  // Drive inputs on the falling edge, then sample the settled outputs 1 time unit later.
  task automatic tick(input logic ack, input logic z, input logic [5:0] op,
                      input logic [5:0] fn, output logic [17:0] ob);
    @(negedge clk);
    mem_ack = ack;
    zero    = z;
    opcode  = op;
    funct   = fn;
    #1;
    ob = obs;
  endtask

  task automatic test_reset();
    logic [17:0] o;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 6'h00, 6'h00, o);
      checks++;
      if (o !== E_IDLE) begin
        errors++;
        $display("FAIL reset_idle[%0d] got %05h exp %05h", i, o, E_IDLE);
      end
    end
    rst = 1'b0;
    tick(1'b0, 1'b0, 6'h00, 6'h00, o);
    checks++;
    if (o !== E_FETCH) begin
      errors++;
      $display("FAIL first_fetch got %05h exp %05h", o, E_FETCH);
    end
  endtask

  task automatic test_rtype();
    logic [17:0] o;
    logic [17:0] exp [4];
    logic [5:0]  fns  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0]  alus [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [17:0] ex;
    int wb_cnt;
    for (int k = 0; k < 5; k++) begin
      ex = E_EXEC_ADD;
      ex[7:5] = alus[k];
      exp = '{E_FETCH_ACK, E_DECODE, ex, E_ALUWB};
      wb_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        tick(1'b1, 1'b0, 6'h00, fns[k], o);
        if (o[4] && o[3]) wb_cnt++;
        checks++;
        if (o !== exp[i]) begin
          errors++;
          $display("FAIL rtype_f%02h[%0d] got %05h exp %05h", fns[k], i, o, exp[i]);
        end
      end
      checks++;
      if (wb_cnt !== 1) begin
        errors++;
        $display("FAIL rtype_f%02h_wb_cycles got %0d exp 1", fns[k], wb_cnt);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [17:0] o;
    logic [17:0] exp [9] = '{E_FETCH_ACK, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD,
                             E_MEMRD, E_MEMRD, E_MEMWB, E_FETCH};
    logic        ack [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int waits = 0;
    for (int i = 0; i < 9; i++) begin
      tick(ack[i], 1'b0, 6'h23, 6'h00, o);
      if (o[17] && o[15] && !ack[i]) waits++;
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL lw[%0d] got %05h exp %05h", i, o, exp[i]);
      end
    end
    checks++;
    if (waits !== 3) begin
      errors++;
      $display("FAIL lw_memrd_waits got %0d exp 3", waits);
    end
  endtask

  task automatic test_beq();
    logic [17:0] o;
    logic [17:0] exp [6] = '{E_FETCH_ACK, E_DECODE, E_BR_T, E_FETCH_ACK, E_DECODE, E_BR_NT};
    logic        z   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, z[i], 6'h04, 6'h00, o);
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL beq[%0d] got %05h exp %05h", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [17:0] o;
    logic [17:0] exp [7] = '{E_FETCH_ACK, E_DECODE_ILL, E_FETCH, E_FETCH_ACK, E_DECODE,
                             E_EXEC_ILL, E_FETCH};
    logic        ack [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0]  op  [7] = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    int wr = 0;
    int ill = 0;
    for (int i = 0; i < 7; i++) begin
      tick(ack[i], 1'b0, op[i], 6'h3F, o);
      if (o[4]) wr++;
      if (o[1]) ill++;
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL illegal[%0d] got %05h exp %05h", i, o, exp[i]);
      end
    end
    checks++;
    if (wr !== 0 || ill !== 2) begin
      errors++;
      $display("FAIL illegal_counts got wr=%0d ill=%0d exp wr=0 ill=2", wr, ill);
    end
  endtask

  task automatic test_addi();
    logic [17:0] o;
    logic [17:0] exp [4] = '{E_FETCH_ACK, E_DECODE, E_ADDIEX, E_ADDIWB};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 6'h08, 6'h00, o);
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL addi[%0d] got %05h exp %05h", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] o;
    logic [17:0] exp [4] = '{E_FETCH_ACK, E_DECODE, E_MEMADR, E_MEMWR};
    logic        ack [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(ack[i], 1'b0, 6'h2B, 6'h00, o);
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL rstmid_pre[%0d] got %05h exp %05h", i, o, exp[i]);
      end
    end
    rst = 1'b1;
    tick(1'b0, 1'b0, 6'h2B, 6'h00, o);
    checks++;
    if (o[17] !== 1'b0 || o[16] !== 1'b0 || o[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop got req=%b we=%b busy=%b exp 0 0 0", o[17], o[16], o[0]);
    end
    checks++;
    if (o !== E_IDLE) begin
      errors++;
      $display("FAIL rstmid_idle got %05h exp %05h", o, E_IDLE);
    end
    rst = 1'b0;
    tick(1'b0, 1'b0, 6'h00, 6'h00, o);
    checks++;
    if (o !== E_FETCH) begin
      errors++;
      $display("FAIL rstmid_refetch got %05h exp %05h", o, E_FETCH);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] o;
    logic [17:0] exp [8] = '{E_FETCH_ACK, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH_ACK,
                             E_DECODE, E_JUMP, E_FETCH};
    logic        ack [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0]  op  [8] = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h02, 6'h02, 6'h02, 6'h00};
    int we_cnt = 0;
    int fetch_pc = 0;
    int jmp = 0;
    for (int i = 0; i < 8; i++) begin
      tick(ack[i], 1'b0, op[i], 6'h00, o);
      if (o[16]) we_cnt++;
      if (o[17] && o[13]) fetch_pc++;
      if (o[13] && o[12:11] == 2'b10) jmp++;
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got %05h exp %05h", i, o, exp[i]);
      end
    end
    checks++;
    if (we_cnt !== 1 || fetch_pc !== 2 || jmp !== 1) begin
      errors++;
      $display("FAIL b2b_counts got we=%0d fetch_pc=%0d jmp=%0d exp 1 2 1", we_cnt, fetch_pc, jmp);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_addi();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
